// File: rtl/nn_address_generator.sv
// ---------------------------------------------------------------------------
// nn_address_generator
//
// Walks every (neuron, input) pair of one neural-network layer and issues an
// input-buffer address and a weight-memory address per beat for the MAC/ALU
// datapath. The last beat of each neuron's dot product is flagged, and a
// sticky done is raised once the whole layer has been issued.
//
// Optional feature macro:
//   NN_AG_BIAS_EN  - when defined, every neuron gets one extra "bias" beat
//                    after its last input. That beat points at the neuron's
//                    bias weight slot (weight stride becomes N_INPUTS+1), drives
//                    in_addr=0 and carries last_input instead of input
//                    N_INPUTS-1.
//
// Parameters:
//   N_INPUTS     inputs per neuron (>= 1)
//   N_NEURONS    neurons per layer (>= 1)
//   ADDR_W       width of in_addr / w_addr / neuron_idx
//   WEIGHT_BASE  weight-memory address of neuron 0 / input 0
//
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   ag_rst      in   synchronous restart (wins over ag_read)
//   ag_read     in   advance enable, one beat per cycle while high
//   in_addr     out  input-buffer address (input index, 0 on bias beats)
//   w_addr      out  weight-memory address, (WEIGHT_BASE + beat) mod 2^ADDR_W
//   addr_valid  out  addresses issued this cycle
//   last_input  out  current beat closes a neuron's dot product
//   neuron_idx  out  neuron that owns the current beat
//   done        out  sticky, layer fully issued
//   state_dbg   out  current FSM state (IDLE=0, RUN=1, DONE=2) for observation
//
// Handshake: ag_read is a plain enable with no back-pressure. Each cycle it is
// sampled high (with ag_rst low, layer not finished) issues exactly one beat,
// visible on the outputs with addr_valid=1 one cycle later. There is no
// ready; the consumer must accept every valid beat.
// ---------------------------------------------------------------------------
module nn_address_generator #(
  parameter int N_INPUTS    = 4,
  parameter int N_NEURONS   = 2,
  parameter int ADDR_W      = 8,
  parameter int WEIGHT_BASE = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ag_rst,
  input  logic              ag_read,
  output logic [ADDR_W-1:0] in_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              addr_valid,
  output logic              last_input,
  output logic [ADDR_W-1:0] neuron_idx,
  output logic              done,
  output logic [1:0]        state_dbg
);

`ifdef NN_AG_BIAS_EN
  localparam bit BIAS_EN          = 1'b1;
  localparam int BEATS_PER_NEURON = N_INPUTS + 1;
`else
  localparam bit BIAS_EN          = 1'b0;
  localparam int BEATS_PER_NEURON = N_INPUTS;
`endif

  // Per-neuron beat index at which the dot product closes; with bias beats
  // enabled this is the bias slot (index N_INPUTS), otherwise N_INPUTS-1.
  localparam logic [ADDR_W-1:0] LAST_BEAT   = ADDR_W'(BEATS_PER_NEURON - 1);
  localparam logic [ADDR_W-1:0] LAST_NEURON = ADDR_W'(N_NEURONS - 1);
  localparam logic [ADDR_W-1:0] BIAS_IDX    = ADDR_W'(N_INPUTS);
  localparam logic [ADDR_W-1:0] W_START     = ADDR_W'(WEIGHT_BASE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] in_idx;
  logic [ADDR_W-1:0] n_idx;
  logic [ADDR_W-1:0] w_ptr;

  // Beat decode from the current counters (used only when a beat issues).
  logic [ADDR_W-1:0] beat_in_addr;
  logic              beat_last;
  logic              beat_final;

  always_comb begin
    beat_in_addr = in_idx;
    beat_last    = 1'b0;
    beat_final   = 1'b0;
    // The bias beat reads no input, so it presents address 0.
    if (BIAS_EN && (in_idx == BIAS_IDX)) begin
      beat_in_addr = '0;
    end
    if (in_idx == LAST_BEAT) begin
      beat_last = 1'b1;
      if (n_idx == LAST_NEURON) begin
        beat_final = 1'b1;
      end
    end
  end

  // Single FSM block: state, counters and all registered outputs.
  // The weight pointer simply increments per beat; because the bias slot (if
  // any) is just another beat, the per-neuron stride falls out naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      in_idx     <= '0;
      n_idx      <= '0;
      w_ptr      <= W_START;
      in_addr    <= '0;
      w_addr     <= '0;
      neuron_idx <= '0;
      addr_valid <= 1'b0;
      last_input <= 1'b0;
      done       <= 1'b0;
    end else if (ag_rst) begin
      state      <= S_IDLE;
      in_idx     <= '0;
      n_idx      <= '0;
      w_ptr      <= W_START;
      in_addr    <= '0;
      w_addr     <= '0;
      neuron_idx <= '0;
      addr_valid <= 1'b0;
      last_input <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_RUN: begin
          if (ag_read) begin
            in_addr    <= beat_in_addr;
            w_addr     <= w_ptr;
            neuron_idx <= n_idx;
            addr_valid <= 1'b1;
            last_input <= beat_last;
            w_ptr      <= w_ptr + ADDR_W'(1);
            if (beat_last) begin
              in_idx <= '0;
              n_idx  <= n_idx + ADDR_W'(1);
            end else begin
              in_idx <= in_idx + ADDR_W'(1);
            end
            if (beat_final) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end else begin
            // Pause: addresses and counters hold, strobes drop.
            addr_valid <= 1'b0;
            last_input <= 1'b0;
          end
        end
        S_DONE: begin
          // Layer exhausted: ag_read is ignored until a restart.
          addr_valid <= 1'b0;
          last_input <= 1'b0;
          done       <= 1'b1;
        end
        default: begin
          state      <= S_IDLE;
          addr_valid <= 1'b0;
          last_input <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

  // last_input is a qualifier of a valid beat, never a standalone strobe.
  a_last_needs_valid : assert property (
    @(posedge clk) disable iff (!reset_n) last_input |-> addr_valid
  );

  // Once the layer is finished no further beats may appear until a restart.
  a_no_beat_after_done : assert property (
    @(posedge clk) disable iff (!reset_n) (done && !ag_rst) |=> !addr_valid
  );

endmodule

// File: tb/tb_nn_address_generator.sv
// ---------------------------------------------------------------------------
// tb_nn_address_generator
//
// Drives nn_address_generator with directed sequences from its operating
// description plus a randomized ag_read/ag_rst stream, and compares every
// output each cycle against a reference model that derives the expected beat
// purely from the count of beats issued since the last restart.
// Works in both the default build and with NN_AG_BIAS_EN defined (then the
// weight base is set to 16).
// ---------------------------------------------------------------------------
module tb_nn_address_generator;

  localparam int N_INPUTS  = 4;
  localparam int N_NEURONS = 2;
  localparam int ADDR_W    = 8;
`ifdef NN_AG_BIAS_EN
  localparam int WB        = 16;
  localparam int PER       = N_INPUTS + 1;
`else
  localparam int WB        = 0;
  localparam int PER       = N_INPUTS;
`endif
  localparam int TOTAL     = N_NEURONS * PER;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;
  logic ag_rst;
  logic ag_read;

  logic [ADDR_W-1:0] in_addr;
  logic [ADDR_W-1:0] w_addr;
  logic              addr_valid;
  logic              last_input;
  logic [ADDR_W-1:0] neuron_idx;
  logic              done;
  logic [1:0]        state_dbg;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  nn_address_generator #(
    .N_INPUTS   (N_INPUTS),
    .N_NEURONS  (N_NEURONS),
    .ADDR_W     (ADDR_W),
    .WEIGHT_BASE(WB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ag_rst    (ag_rst),
    .ag_read   (ag_read),
    .in_addr   (in_addr),
    .w_addr    (w_addr),
    .addr_valid(addr_valid),
    .last_input(last_input),
    .neuron_idx(neuron_idx),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard / model ----------------
  int checks   = 0;
  int failures = 0;

  logic [ADDR_W-1:0] exp_q[$];   // weight addresses of beats issued by the model

  int                beats;      // beats issued since last restart
  logic [ADDR_W-1:0] m_in;
  logic [ADDR_W-1:0] m_w;
  logic [ADDR_W-1:0] m_n;
  logic              m_v;
  logic              m_last;
  logic              m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    beats  = 0;
    m_in   = '0;
    m_w    = '0;
    m_n    = '0;
    m_v    = 1'b0;
    m_last = 1'b0;
    m_done = 1'b0;
  endtask

  // Expected register contents after one clock edge with the given inputs.
  task automatic model_step(input logic rd, input logic rs);
    int j;
    if (rs) begin
      model_reset();
    end else if (m_done || !rd) begin
      m_v    = 1'b0;
      m_last = 1'b0;
    end else begin
      j      = beats % PER;
      m_in   = (j >= N_INPUTS) ? '0 : ADDR_W'(j);
      m_w    = ADDR_W'((WB + beats) % (1 << ADDR_W));
      m_n    = ADDR_W'(beats / PER);
      m_v    = 1'b1;
      m_last = (j == PER - 1);
      beats++;
      if (beats == TOTAL) m_done = 1'b1;
      exp_q.push_back(m_w);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".in_addr"},    in_addr,    m_in);
    check({tag, ".w_addr"},     w_addr,     m_w);
    check({tag, ".neuron_idx"}, neuron_idx, m_n);
    check({tag, ".valid"},      addr_valid, m_v);
    check({tag, ".last"},       last_input, m_last);
    check({tag, ".done"},       done,       m_done);
    if (addr_valid === 1'b1) begin
      if (exp_q.size() > 0) check({tag, ".sb_w"}, w_addr, exp_q.pop_front());
      else                  check({tag, ".sb_extra"}, addr_valid, 1'b0);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic rd, input logic rs, input string tag);
    @(negedge clk);
    ag_read = rd;
    ag_rst  = rs;
    model_step(rd, rs);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    ag_rst  = 1'b0;
    ag_read = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    reset_n = 1'b1;

    // Full layer with ag_read held, then extra reads after done.
    for (int i = 0; i < TOTAL; i++) cycle(1'b1, 1'b0, "stream");
    check("stream.done_end", done, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, "post_done");
    check("post_done.w_hold", w_addr, ADDR_W'(WB + TOTAL - 1));

    // Alternating ag_read: beats spread over twice as many cycles.
    cycle(1'b0, 1'b1, "restart1");
    for (int i = 0; i < 2 * TOTAL; i++) cycle(((i % 2) == 0), 1'b0, "toggle");
    check("toggle.done_end", done, 1'b1);

    // ag_rst collides with ag_read at beat 5.
    cycle(1'b0, 1'b1, "restart2");
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, "pre_rst");
    cycle(1'b1, 1'b1, "rst_collide");
    check("rst_collide.w_zero", w_addr, 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, "after_rst");

    // Asynchronous reset pulse mid-cycle at beat 2.
    cycle(1'b0, 1'b1, "restart3");
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, "pre_async");
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, "after_async");

    // Randomized ag_read / ag_rst stream.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0), "rand");
    end

    check("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nn_address_generator.md
# nn_address_generator

Address generator feeding the MAC/ALU datapath of the neural-network core. Driven by the control unit's `ag_rst`/`ag_read` strobes, it walks every (neuron, input) pair of one layer and emits input-buffer and weight-memory addresses with a valid strobe. It also flags the last beat of each neuron's dot product and raises a sticky `done` once the layer is exhausted.

## Interface
Parameters:
- `N_INPUTS`, 4, inputs per neuron (≥1)
- `N_NEURONS`, 2, neurons per layer (≥1)
- `ADDR_W`, 8, width of `in_addr`/`w_addr`
- `WEIGHT_BASE`, 0, weight-memory address of neuron 0 / input 0

Ports:
- `clk` in 1: sole clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `ag_rst` in 1: synchronous restart from control unit
- `ag_read` in 1: advance enable; one beat issued per cycle while high
- `in_addr` out `ADDR_W`: input-buffer address (= input index)
- `w_addr` out `ADDR_W`: weight-memory address
- `addr_valid` out 1: addresses valid this cycle
- `last_input` out 1: current beat closes a neuron's dot product
- `neuron_idx` out `ADDR_W`: neuron owning current beat
- `done` out 1: sticky, layer fully issued

## Operation
- Decided: one clock `clk`; reset `reset_n` asynchronous, active-low.
- States: IDLE (counters zero, nothing issued), RUN (mid-layer), DONE.
- Internal counters: `in_idx` 0..N_INPUTS-1, `n_idx` 0..N_NEURONS-1, running weight pointer `w_ptr` (incremented by 1 per beat; no multiplier).
- Beat issue (IDLE or RUN, `ag_read`=1, `ag_rst`=0): output regs load `in_addr`=in_idx, `w_addr`=w_ptr, `neuron_idx`=n_idx, `addr_valid`=1, `last_input`=(in_idx==N_INPUTS-1); counters advance.
- `in_idx` wraps to 0 after N_INPUTS-1 and `n_idx` increments.
- IDLE→RUN on first beat; RUN→DONE when the beat with in_idx==N_INPUTS-1 and n_idx==N_NEURONS-1 issues; `done` rises with that beat's outputs (same edge).
- DONE: `ag_read` ignored, `addr_valid`=0, addresses hold last values, `done`=1 until `ag_rst` or `reset_n`.
- `ag_read`=0 in RUN: pause; `addr_valid`=0, `last_input`=0, address outputs hold, counters hold.
- `ag_rst`=1: next edge → IDLE, counters and all outputs 0; overrides `ag_read` when simultaneous.
- Widths: `w_addr` = (WEIGHT_BASE + beat count) mod 2^ADDR_W; overflow wraps silently, sizing is integrator's duty.

## Timing
- All outputs registered; latency 1 cycle from `ag_read` sample to `addr_valid`.
- Throughput one beat/cycle; layer of N_NEURONS·N_INPUTS beats completes in that many `ag_read`-high cycles.
- `reset_n` low: immediately all outputs 0, state IDLE, regardless of clock; mid-layer assertion discards progress.
- Reset values: `in_addr`, `w_addr`, `neuron_idx` = 0; `addr_valid`, `last_input`, `done` = 0.
- `last_input` only ever high together with `addr_valid`.

## Configuration
- `NN_AG_BIAS_EN` defined: each neuron gets one extra beat after its last input; beat issues `w_addr`=bias slot (weights stride N_INPUTS+1 per neuron), `in_addr`=0, `last_input`=1 on the bias beat only (not on input N_INPUTS-1); layer length N_NEURONS·(N_INPUTS+1).
- Undefined: no bias beats, stride N_INPUTS, behaviour as above.

## Test plan
- Defaults, `reset_n` release, `ag_read` held 8 cycles → `w_addr` 0..7, `in_addr` 0,1,2,3,0,1,2,3, `last_input` on beats 3 and 7, `done`=1 with beat 7.
- `ag_read` toggled 1/0 alternately → 8 beats spread over 16 cycles, addresses hold during gaps, `addr_valid` only on issue cycles.
- `ag_rst` and `ag_read` both high at beat 5 → next cycle all outputs 0; subsequent `ag_read` restarts at `w_addr`=0.
- `reset_n` pulsed low mid-cycle at beat 2 → outputs clear asynchronously before next edge, `done`=0.
- After `done`, `ag_read` held 4 cycles → `addr_valid` stays 0, `done` stays 1, `w_addr` stays 7.
- `NN_AG_BIAS_EN`, WEIGHT_BASE=16 → `w_addr` 16..25, `last_input` only on beats 4 and 9 (bias beats), `done` with beat 9.
